// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage types and constants for the IF fetch queue.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam int unsigned ROM_ADDR_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetchq_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetchq_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo_mem.sv
// Fetch queue storage: DEPTH entries of {instr, pc4}, synchronous write, asynchronous read.
module fetchq_fifo_mem
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] wr_ptr_i,
    input  fetchq_entry_t wdata_i,
    input  logic [PW-1:0] rd_ptr_i,
    output fetchq_entry_t rdata_o
);

    fetchq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_ptr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: drives ROM address, queues {instr, PC+4} ahead of IF/ID, flushes on redirect.
// Optional perf counters (flush_cnt, starve_cnt) are built when IF_FETCHQ_PERF_EN is defined.
module if_fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              valid_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [31:0]       pc_out,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       starve_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetchq_state_t state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic          push, pop;
    fetchq_entry_t wr_entry, head;

    assign valid_out = (count_q != '0);
    assign pop       = id_ready && valid_out && !redirect;
    // A full queue may still accept a push when the head leaves on the same edge.
    assign push      = (state_q == RUN) && !redirect && ((count_q < FULL) || pop);
    assign rom_addr  = fetch_pc_q[ADDR_W-1:0];

    assign wr_entry.instr = 32'(rom_data);
    assign wr_entry.pc4   = fetch_pc_q + PC_STEP;

    always_comb begin
        state_d    = fetch_en ? RUN : IDLE;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    fetchq_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .we_i     (push),
        .wr_ptr_i (wr_ptr_q),
        .wdata_i  (wr_entry),
        .rd_ptr_i (rd_ptr_q),
        .rdata_o  (head)
    );

    assign instr_out = valid_out ? DATA_W'(head.instr) : DATA_W'(NOP_INSTR);
    assign pc_out    = valid_out ? head.pc4 : 32'h0;

`ifdef IF_FETCHQ_PERF_EN
    logic [15:0] flush_cnt_q, flush_cnt_d, starve_cnt_q, starve_cnt_d;

    always_comb begin
        flush_cnt_d  = flush_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if ((state_q == RUN) && (count_q == '0) && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            flush_cnt_q  <= flush_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign flush_cnt  = flush_cnt_q;
    assign starve_cnt = starve_cnt_q;
`else
    assign flush_cnt  = '0;
    assign starve_cnt = '0;
`endif

endmodule
